muldiv_seq: RTL and testbench
=============================

# muldiv_seq

Multi-cycle sequencer for the RV64M multiply/divide operations, sitting beside the ALU in the execute stage. It accepts one operation at a time from the control unit, iterates a single shared add/subtract datapath once per bit, and applies sign correction. It returns the 64-bit result with a one-cycle `done` pulse. The control unit holds the pipeline while `busy` is high.

## Interface
- `SIZE`, 64, operand/result width in bits (≥ 8, power of two).

- `clk` in 1: rising-edge clock.
- `reset` in 1: asynchronous, active-high; clears all state.
- `start` in 1: request an operation; sampled only when `busy`=0.
- `funct3` in 3: M-extension selector. 000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU.
- `s1` in SIZE: rs1 operand (multiplicand / dividend).
- `s2` in SIZE: rs2 operand (multiplier / divisor).
- `busy` out 1: operation in progress; `start` is ignored.
- `done` out 1: one-cycle pulse; `res` is valid from this cycle on.
- `res` out SIZE: result, held until the next accepted `start` completes.

## Operation
- States:
  - IDLE: `busy`=0.
  - CALC: `busy`=1; internal counter runs 0..SIZE-1.
  - FIX: `busy`=1; single cycle.
- Accept:
  - In IDLE, `start`=1 at an edge latches `s1`, `s2` and `funct3` and goes to CALC with the counter at 0.
  - Later changes on the inputs have no effect on the running operation.
- Operand preparation:
  - Signed operands (MULH: both; MULHSU: `s1` only; DIV/REM: both) are converted to magnitudes.
  - The result sign is recorded. Quotient sign = sign(s1) XOR sign(s2). Remainder sign = sign(s1).
- CALC, one iteration per cycle:
  - Multiply: shift-and-add into a 2·SIZE-bit product register.
  - Divide: restoring shift-subtract, producing a SIZE-bit quotient and remainder.
  - Exactly one SIZE-bit add or subtract is performed per cycle.
  - After iteration SIZE-1, go to FIX.
- FIX:
  - Negate (two's complement) if the recorded sign is negative.
  - Select the output: MUL gives the low SIZE bits. MULH/MULHSU/MULHU give the high SIZE bits. DIV/DIVU give the quotient. REM/REMU give the remainder.
  - Register `res`, pulse `done`, return to IDLE.
- Special cases (RISC-V defined, no traps):
  - Divide by zero: DIV/DIVU → all ones; REM/REMU → `s1`.
  - Signed overflow (`s1`=100…0, `s2`=all ones): DIV → `s1`; REM → 0.
- Reset at any time: state goes to IDLE and `busy`=0, `done`=0, `res`=0. An in-flight operation is discarded with no `done`.

## Timing
- Reset values: `busy`=0, `done`=0, `res`=0.
- Let E0 be the edge that accepts `start`:
  - `busy` rises after E0.
  - CALC covers edges E1..E(SIZE).
  - FIX is the edge E(SIZE+1), which writes `res`, raises `done` and drops `busy`.
- Latency is SIZE+1 cycles from accept to `done` (65 for SIZE=64).
- `done` is high for exactly one cycle and coincides with `busy`=0.
- A `start` in the `done` cycle is accepted (back-to-back issue).
- Throughput is one operation per SIZE+1 cycles.
- `start` while `busy`=1 is dropped silently and is not queued.

## Configuration
- `MULDIV_EARLY_OUT_EN`:
  - Defined: divide-by-zero and signed-overflow cases skip CALC. Edge E1 writes the special result, pulses `done` and returns to IDLE, giving a latency of 1 cycle.
  - Not defined: these cases take the full SIZE+1 cycles. `res` still carries the special-case values listed under Operation.
  - All multiply latencies are unaffected.

## Test plan
- Reset mid-operation: assert `reset` 10 cycles after a DIVU accept → `busy`=0, `done`=0 and `res`=0 immediately. No `done` pulse follows.
- MUL/MULHU: `s1`=0xFFFF_FFFF_FFFF_FFFF, `s2`=2.
  - MUL → `res`=0xFFFF_FFFF_FFFF_FFFE.
  - MULHU → `res`=1.
  - `done` arrives exactly 65 cycles after accept.
- Signed ops: `s1`=-7, `s2`=2.
  - DIV → -3 (0xFFFF_FFFF_FFFF_FFFD).
  - REM → -1.
  - MULH → 0xFFFF_FFFF_FFFF_FFFF.
  - MULHSU with `s2`=0x8000_0000_0000_0000 → 0xFFFF_FFFF_FFFF_FFFC.
- Special cases:
  - DIVU by 0 → all ones.
  - REM of 5 by 0 → 5.
  - DIV of 0x8000_0000_0000_0000 by -1 → 0x8000_0000_0000_0000.
  - REM of the same operands → 0.
  - Latency is 1 cycle with `MULDIV_EARLY_OUT_EN` defined, 65 without.
- Handshake:
  - `start` pulses while `busy` → ignored, and `res` matches the first operation only.
  - `start` in the `done` cycle → a second operation is accepted and its `done` follows 65 cycles later.

Source files
------------

// File: rtl/muldiv_seq.sv
// Sequential RV64M multiply/divide unit: one shared add/subtract per cycle, SIZE+1 cycle latency.
// Optional MULDIV_EARLY_OUT_EN: divide-by-zero and signed overflow finish one cycle after accept.
module muldiv_seq #(
  parameter int SIZE = 64
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            start,
  input  logic [2:0]      funct3,
  input  logic [SIZE-1:0] s1,
  input  logic [SIZE-1:0] s2,
  output logic            busy,
  output logic            done,
  output logic [SIZE-1:0] res
);

  localparam int CW = $clog2(SIZE);

  typedef enum logic [1:0] {IDLE, CALC, FIX} state_t;

  state_t              state_q, state_d;
  logic [CW-1:0]       cnt_q, cnt_d;
  logic [2:0]          op_q, op_d;
  logic [SIZE-1:0]     b_q, b_d;
  logic [2*SIZE-1:0]   acc_q, acc_d;
  logic                neg_q, neg_d;
  logic                spec_q, spec_d;
  logic [SIZE-1:0]     spec_val_q, spec_val_d;
  logic [SIZE-1:0]     res_q, res_d;
  logic                done_q, done_d;

  // Operand preparation, evaluated on the incoming request
  logic                s1_sgn, s2_sgn, s1_neg, s2_neg;
  logic [SIZE-1:0]     s1_mag, s2_mag;
  logic                div_zero, div_ovf, special, neg_in;
  logic [SIZE-1:0]     spec_val_in;

  always_comb begin
    s1_sgn      = funct3[2] ? ~funct3[0] : (funct3[1:0] == 2'b01 || funct3[1:0] == 2'b10);
    s2_sgn      = funct3[2] ? ~funct3[0] : (funct3[1:0] == 2'b01);
    s1_neg      = s1_sgn & s1[SIZE-1];
    s2_neg      = s2_sgn & s2[SIZE-1];
    s1_mag      = s1_neg ? (~s1 + 1'b1) : s1;
    s2_mag      = s2_neg ? (~s2 + 1'b1) : s2;
    div_zero    = funct3[2] & (s2 == '0);
    div_ovf     = funct3[2] & ~funct3[0] & (s1 == {1'b1, {(SIZE-1){1'b0}}}) & (&s2);
    special     = div_zero | div_ovf;
    spec_val_in = div_zero ? (funct3[1] ? s1 : '1) : (funct3[1] ? '0 : s1);
    // Remainder takes the dividend's sign; quotient and products take the XOR
    neg_in      = (funct3[2] & funct3[1]) ? s1_neg : (s1_neg ^ s2_neg);
  end

  // Shared datapath: hi + multiplicand for multiply, shifted remainder - divisor for divide
  logic [SIZE-1:0]   hi, lo;
  logic              is_div;
  logic [SIZE:0]     rem_sh, add_a, add_b;
  logic [SIZE+1:0]   sum;
  logic              ge;
  logic [2*SIZE-1:0] step;

  always_comb begin
    hi     = acc_q[2*SIZE-1:SIZE];
    lo     = acc_q[SIZE-1:0];
    is_div = op_q[2];
    rem_sh = {hi, lo[SIZE-1]};
    add_a  = is_div ? rem_sh : {1'b0, hi};
    add_b  = is_div ? ~{1'b0, b_q} : (lo[0] ? {1'b0, b_q} : '0);
    sum    = {1'b0, add_a} + {1'b0, add_b} + {{(SIZE+1){1'b0}}, is_div};
    ge     = sum[SIZE+1];
    if (is_div)
      step = {(ge ? sum[SIZE-1:0] : rem_sh[SIZE-1:0]), lo[SIZE-2:0], ge};
    else
      step = {sum[SIZE:0], lo[SIZE-1:1]};
  end

  // Final sign correction and result selection
  logic [2*SIZE-1:0] sel2, fix2;
  logic [SIZE-1:0]   fix_res;

  always_comb begin
    sel2 = op_q[2] ? {{SIZE{1'b0}}, (op_q[1] ? hi : lo)} : acc_q;
    fix2 = neg_q ? (~sel2 + 1'b1) : sel2;
    if (spec_q)
      fix_res = spec_val_q;
    else if (op_q[2] || op_q[1:0] == 2'b00)
      fix_res = fix2[SIZE-1:0];
    else
      fix_res = fix2[2*SIZE-1:SIZE];
  end

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    op_d       = op_q;
    b_d        = b_q;
    acc_d      = acc_q;
    neg_d      = neg_q;
    spec_d     = spec_q;
    spec_val_d = spec_val_q;
    res_d      = res_q;
    done_d     = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) begin
          op_d       = funct3;
          b_d        = funct3[2] ? s2_mag : s1_mag;
          acc_d      = {{SIZE{1'b0}}, (funct3[2] ? s1_mag : s2_mag)};
          neg_d      = neg_in;
          spec_d     = special;
          spec_val_d = spec_val_in;
          cnt_d      = '0;
`ifdef MULDIV_EARLY_OUT_EN
          state_d    = special ? FIX : CALC;
`else
          state_d    = CALC;
`endif
        end
      end
      CALC: begin
        acc_d = step;
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == CW'(SIZE-1))
          state_d = FIX;
      end
      FIX: begin
        res_d   = fix_res;
        done_d  = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      op_q       <= '0;
      b_q        <= '0;
      acc_q      <= '0;
      neg_q      <= 1'b0;
      spec_q     <= 1'b0;
      spec_val_q <= '0;
      res_q      <= '0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      op_q       <= op_d;
      b_q        <= b_d;
      acc_q      <= acc_d;
      neg_q      <= neg_d;
      spec_q     <= spec_d;
      spec_val_q <= spec_val_d;
      res_q      <= res_d;
      done_q     <= done_d;
    end
  end

  assign busy = (state_q != IDLE);
  assign done = done_q;
  assign res  = res_q;

endmodule

// File: tb/tb_muldiv_seq.sv
// Directed bench for muldiv_seq: results, latency, reset abort and start handshake.
module tb_muldiv_seq;

  localparam logic [2:0] F_MUL = 3'b000, F_MULH = 3'b001, F_MULHSU = 3'b010, F_MULHU = 3'b011;
  localparam logic [2:0] F_DIV = 3'b100, F_DIVU = 3'b101, F_REM = 3'b110, F_REMU = 3'b111;
  localparam int LAT = 65;
`ifdef MULDIV_EARLY_OUT_EN
  localparam int SP_LAT = 1;
`else
  localparam int SP_LAT = 65;
`endif

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        start = 1'b0;
  logic [2:0]  funct3 = 3'b000;
  logic [63:0] s1 = '0, s2 = '0;
  logic        busy, done;
  logic [63:0] res;

  int total = 0;
  int passed = 0;
  int fails = 0;

  muldiv_seq #(.SIZE(64)) dut (
    .clk(clk), .reset(reset), .start(start), .funct3(funct3),
    .s1(s1), .s2(s2), .busy(busy), .done(done), .res(res)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) passed++;
    else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input logic [2:0] f, input logic [63:0] a, input logic [63:0] b);
    funct3 = f; s1 = a; s2 = b; start = 1'b1;
    cyc();
    start = 1'b0;
  endtask

  task automatic wait_done(output int n);
    n = 0;
    do begin
      cyc();
      n++;
    end while (!done && n < 300);
  endtask

  task automatic run_op(input string tag, input logic [2:0] f, input logic [63:0] a,
                        input logic [63:0] b, input logic [63:0] exp, input int lat);
    int n;
    issue(f, a, b);
    check({tag, " busy"}, 64'(busy), 64'd1);
    wait_done(n);
    check({tag, " latency"}, 64'(n), 64'(lat));
    check({tag, " res"}, res, exp);
    check({tag, " busy@done"}, 64'(busy), 64'd0);
    cyc();
    check({tag, " done pulse"}, 64'(done), 64'd0);
    $display("op %s f=%b s1=%h s2=%h res=%h lat=%0d", tag, f, a, b, res, n);
  endtask

  initial begin
    int n, n2;
    bit seen;
    repeat (3) cyc();
    check("reset busy", 64'(busy), 64'd0);
    check("reset done", 64'(done), 64'd0);
    check("reset res", res, 64'd0);
    #2 reset = 1'b0;
    cyc();

    run_op("MUL", F_MUL, 64'hFFFF_FFFF_FFFF_FFFF, 64'd2, 64'hFFFF_FFFF_FFFF_FFFE, LAT);

    // Abort a DIVU mid-flight
    issue(F_DIVU, 64'd100, 64'd7);
    repeat (10) cyc();
    #2 reset = 1'b1;
    #1;
    check("abort busy", 64'(busy), 64'd0);
    check("abort done", 64'(done), 64'd0);
    check("abort res", res, 64'd0);
    #3 reset = 1'b0;
    seen = 1'b0;
    for (int i = 0; i < 80; i++) begin
      cyc();
      if (done) seen = 1'b1;
    end
    check("abort no done", 64'(seen), 64'd0);
    $display("op abort DIVU res=%h", res);

    run_op("MULHU", F_MULHU, 64'hFFFF_FFFF_FFFF_FFFF, 64'd2, 64'd1, LAT);
    run_op("MUL neg", F_MUL, -64'sd3, 64'd5, 64'hFFFF_FFFF_FFFF_FFF1, LAT);
    run_op("DIV", F_DIV, -64'sd7, 64'd2, 64'hFFFF_FFFF_FFFF_FFFD, LAT);
    run_op("REM", F_REM, -64'sd7, 64'd2, 64'hFFFF_FFFF_FFFF_FFFF, LAT);
    run_op("MULH", F_MULH, -64'sd7, 64'd2, 64'hFFFF_FFFF_FFFF_FFFF, LAT);
    run_op("MULHSU", F_MULHSU, -64'sd7, 64'h8000_0000_0000_0000, 64'hFFFF_FFFF_FFFF_FFFC, LAT);
    run_op("DIVU", F_DIVU, 64'd100, 64'd7, 64'd14, LAT);
    run_op("REMU", F_REMU, 64'd100, 64'd7, 64'd2, LAT);
    run_op("DIVU/0", F_DIVU, 64'd123, 64'd0, 64'hFFFF_FFFF_FFFF_FFFF, SP_LAT);
    run_op("DIV neg/0", F_DIV, -64'sd7, 64'd0, 64'hFFFF_FFFF_FFFF_FFFF, SP_LAT);
    run_op("REM/0", F_REM, 64'd5, 64'd0, 64'd5, SP_LAT);
    run_op("DIV ovf", F_DIV, 64'h8000_0000_0000_0000, 64'hFFFF_FFFF_FFFF_FFFF,
           64'h8000_0000_0000_0000, SP_LAT);
    run_op("REM ovf", F_REM, 64'h8000_0000_0000_0000, 64'hFFFF_FFFF_FFFF_FFFF, 64'd0, SP_LAT);

    // start pulses while busy are dropped and operands are held internally
    issue(F_MUL, 64'd3, 64'd4);
    repeat (4) cyc();
    funct3 = F_DIVU; s1 = 64'd999; s2 = 64'd3; start = 1'b1;
    cyc();
    start = 1'b0; s1 = 64'd55;
    wait_done(n2);
    n = 5 + n2;
    check("ignored latency", 64'(n), 64'(LAT));
    check("ignored res", res, 64'd12);
    seen = 1'b0;
    for (int i = 0; i < 70; i++) begin
      cyc();
      if (done) seen = 1'b1;
    end
    check("ignored not queued", 64'(seen), 64'd0);
    $display("op ignored-start MUL res=%h lat=%0d", res, n);

    // start in the done cycle is accepted back-to-back
    issue(F_MUL, 64'd6, 64'd7);
    wait_done(n);
    check("b2b first res", res, 64'd42);
    check("b2b first busy", 64'(busy), 64'd0);
    issue(F_DIVU, 64'd100, 64'd7);
    check("b2b second busy", 64'(busy), 64'd1);
    wait_done(n);
    check("b2b second latency", 64'(n), 64'(LAT));
    check("b2b second res", res, 64'd14);
    $display("op back-to-back DIVU res=%h lat=%0d", res, n);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
